// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: bundles the pipeline-facing signals of hazard_ctrl.
//   master : pipeline side (drives decode/EX/IRQ info, consumes controls)
//   slave  : hazard_ctrl side
interface hazard_ctrl_if;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        ex_mem_read;
  logic [4:0]  ex_rt;
  logic        branch_taken;
  logic        md_start;
  logic        irq_req;
  logic [4:0]  irq_vector;

  logic        pc_write;
  logic        if_id_write;
  logic        if_flush;
  logic        id_ex_flush;
  logic        ex_hold;
  logic        pc_sel_vector;
  logic [4:0]  vector_if_out;
  logic        irq_ack;
  logic [15:0] stall_count;

  modport master (
    output id_rs, id_rt, ex_mem_read, ex_rt, branch_taken, md_start,
           irq_req, irq_vector,
    input  pc_write, if_id_write, if_flush, id_ex_flush, ex_hold,
           pc_sel_vector, vector_if_out, irq_ack, stall_count
  );

  modport slave (
    input  id_rs, id_rt, ex_mem_read, ex_rt, branch_taken, md_start,
           irq_req, irq_vector,
    output pc_write, if_id_write, if_flush, id_ex_flush, ex_hold,
           pc_sel_vector, vector_if_out, irq_ack, stall_count
  );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: front-end pipeline sequencer for the 5-stage core.
// Generates PC / IF/ID / ID/EX controls for load-use stalls, taken
// branches, multi-cycle mul/div holds and interrupt entry.
// Optional macro HAZARD_PERF_EN builds a saturating 16-bit stall counter;
// without it stall_count is tied to zero.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_RUN     | normal issue; load-use, IRQ accept, mul/div start, branch
// ST_MD      | mul/div in EX; front end frozen, IRQs deferred to pending
// ST_DRAIN   | flushing front end before the interrupt redirect
// ST_REDIRECT| one cycle: PC takes vector base, vector injected, irq_ack
module hazard_ctrl #(
  parameter int MD_CYCLES    = 4,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic          clk,
  input  logic          reset,
  hazard_ctrl_if.slave  hz
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MD       = 2'd1,
    ST_DRAIN    = 2'd2,
    ST_REDIRECT = 2'd3
  } state_t;

  // The md_start cycle counts as the first stall cycle, so the counter
  // covers the remaining MD_CYCLES-1 cycles ending at zero.
  localparam logic [3:0] MD_LOAD    = 4'(MD_CYCLES - 2);
  localparam logic [2:0] DRAIN_LOAD = 3'(DRAIN_CYCLES - 1);

  state_t      r_state;
  logic [3:0]  r_md_cnt;
  logic [2:0]  r_drain_cnt;
  logic [4:0]  r_vec;
  logic        r_pend;

  state_t      w_state_nxt;
  logic [3:0]  w_md_cnt_nxt;
  logic [2:0]  w_drain_cnt_nxt;
  logic [4:0]  w_vec_nxt;
  logic        w_pend_nxt;

  logic        w_lu;
  logic        w_pc_write;
  logic        w_if_id_write;
  logic        w_if_flush;
  logic        w_id_ex_flush;
  logic        w_ex_hold;
  logic        w_pc_sel_vector;
  logic        w_irq_ack;
  logic [4:0]  w_vector_out;

  // Load in EX writing a register that the ID instruction reads.
  assign w_lu = hz.ex_mem_read && (hz.ex_rt != 5'd0) &&
                ((hz.ex_rt == hz.id_rs) || (hz.ex_rt == hz.id_rt));

  // State register and sequencing counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_RUN;
      r_md_cnt    <= '0;
      r_drain_cnt <= '0;
      r_vec       <= '0;
      r_pend      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_md_cnt    <= w_md_cnt_nxt;
      r_drain_cnt <= w_drain_cnt_nxt;
      r_vec       <= w_vec_nxt;
      r_pend      <= w_pend_nxt;
    end
  end

  // Next-state and output decode; reset overrides outputs combinationally.
  always_comb begin
    w_state_nxt     = r_state;
    w_md_cnt_nxt    = r_md_cnt;
    w_drain_cnt_nxt = r_drain_cnt;
    w_vec_nxt       = r_vec;
    w_pend_nxt      = r_pend;

    w_pc_write      = 1'b1;
    w_if_id_write   = 1'b1;
    w_if_flush      = 1'b0;
    w_id_ex_flush   = 1'b0;
    w_ex_hold       = 1'b0;
    w_pc_sel_vector = 1'b0;
    w_irq_ack       = 1'b0;
    w_vector_out    = 5'd0;

    case (r_state)
      ST_RUN: begin
        if (w_lu) begin
          // Stale operand: branch outcome and IRQ acceptance both wait.
          w_pc_write    = 1'b0;
          w_if_id_write = 1'b0;
          w_id_ex_flush = 1'b1;
        end else if (hz.irq_req || r_pend) begin
          // A live request carries the freshest vector; otherwise keep
          // the one captured while mul/div was running.
          if (hz.irq_req) begin
            w_vec_nxt = hz.irq_vector;
          end
          w_pend_nxt      = 1'b0;
          w_drain_cnt_nxt = DRAIN_LOAD;
          w_state_nxt     = ST_DRAIN;
          w_pc_write      = 1'b0;
          w_if_flush      = 1'b1;
          w_id_ex_flush   = 1'b1;
        end else if (hz.md_start) begin
          w_md_cnt_nxt  = MD_LOAD;
          w_state_nxt   = ST_MD;
          w_pc_write    = 1'b0;
          w_if_id_write = 1'b0;
          w_ex_hold     = 1'b1;
        end else if (hz.branch_taken) begin
          w_if_flush = 1'b1;
        end
      end

      ST_MD: begin
        w_pc_write    = 1'b0;
        w_if_id_write = 1'b0;
        w_id_ex_flush = 1'b1;
        w_ex_hold     = 1'b1;
        if (hz.irq_req) begin
          w_pend_nxt = 1'b1;
          w_vec_nxt  = hz.irq_vector;
        end
        if (r_md_cnt == 4'd0) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_md_cnt_nxt = r_md_cnt - 4'd1;
        end
      end

      ST_DRAIN: begin
        w_pc_write    = 1'b0;
        w_if_flush    = 1'b1;
        w_id_ex_flush = 1'b1;
        if (r_drain_cnt == 3'd0) begin
          w_state_nxt = ST_REDIRECT;
        end else begin
          w_drain_cnt_nxt = r_drain_cnt - 3'd1;
        end
      end

      ST_REDIRECT: begin
        w_pc_sel_vector = 1'b1;
        w_irq_ack       = 1'b1;
        w_vector_out    = r_vec;
        w_state_nxt     = ST_RUN;
      end

      default: begin
        w_state_nxt = ST_RUN;
      end
    endcase

    if (reset) begin
      w_pc_write      = 1'b0;
      w_if_id_write   = 1'b0;
      w_if_flush      = 1'b1;
      w_id_ex_flush   = 1'b1;
      w_ex_hold       = 1'b0;
      w_pc_sel_vector = 1'b0;
      w_irq_ack       = 1'b0;
      w_vector_out    = 5'd0;
    end
  end

  assign hz.pc_write      = w_pc_write;
  assign hz.if_id_write   = w_if_id_write;
  assign hz.if_flush      = w_if_flush;
  assign hz.id_ex_flush   = w_id_ex_flush;
  assign hz.ex_hold       = w_ex_hold;
  assign hz.pc_sel_vector = w_pc_sel_vector;
  assign hz.irq_ack       = w_irq_ack;
  assign hz.vector_if_out = w_vector_out;

`ifdef HAZARD_PERF_EN
  logic [15:0] r_stall_cnt;

  // Saturating count of edges where the PC was frozen.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cnt <= '0;
    end else if (!w_pc_write && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign hz.stall_count = r_stall_cnt;
`else
  assign hz.stall_count = 16'h0000;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed plus randomized bench for hazard_ctrl with a
// cycle-timestamp reference model (stall windows and interrupt deadlines
// tracked as absolute cycle numbers).
module tb_hazard_ctrl;
  localparam int MD = 4;
  localparam int DR = 2;

  logic clk;
  logic reset;
  hazard_ctrl_if hif ();

  hazard_ctrl #(.MD_CYCLES(MD), .DRAIN_CYCLES(DR)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int          cyc     = 0;
  int          md_last = -1;   // last cycle of the mul/div freeze
  int          acc     = -1;   // cycle the interrupt was accepted
  int          ack_at  = -1;   // cycle of the redirect / irq_ack
  bit          pend    = 1'b0;
  logic [4:0]  pvec    = '0;
  logic [4:0]  lvec    = '0;
  int          sc_model = 0;
  logic        lu_m;
  logic        e_pcw, e_ifid, e_iff, e_idex, e_exh, e_psv, e_ack;
  logic [4:0]  e_vec;
  logic [11:0] exp_o, got_o;
  int          exp_sc;

  always begin
    @(negedge clk);
    #2;
    e_pcw = 1'b1; e_ifid = 1'b1; e_iff = 1'b0; e_idex = 1'b0;
    e_exh = 1'b0; e_psv = 1'b0; e_ack = 1'b0; e_vec = 5'd0;
    if (reset) begin
      e_pcw = 1'b0; e_ifid = 1'b0; e_iff = 1'b1; e_idex = 1'b1;
      md_last = -1; acc = -1; ack_at = -1; pend = 1'b0;
      pvec = '0; lvec = '0; sc_model = 0;
    end else begin
      lu_m = hif.ex_mem_read && (hif.ex_rt != 5'd0) &&
             ((hif.ex_rt == hif.id_rs) || (hif.ex_rt == hif.id_rt));
      if (cyc <= md_last) begin
        e_pcw = 1'b0; e_ifid = 1'b0; e_idex = 1'b1; e_exh = 1'b1;
        if (hif.irq_req) begin
          pend = 1'b1;
          pvec = hif.irq_vector;
        end
      end else if (cyc > acc && cyc < ack_at) begin
        e_pcw = 1'b0; e_iff = 1'b1; e_idex = 1'b1;
      end else if (cyc == ack_at) begin
        e_psv = 1'b1; e_ack = 1'b1; e_vec = lvec;
      end else if (lu_m) begin
        e_pcw = 1'b0; e_ifid = 1'b0; e_idex = 1'b1;
      end else if (hif.irq_req || pend) begin
        lvec   = hif.irq_req ? hif.irq_vector : pvec;
        pend   = 1'b0;
        acc    = cyc;
        ack_at = cyc + DR + 1;
        e_pcw = 1'b0; e_iff = 1'b1; e_idex = 1'b1;
      end else if (hif.md_start) begin
        md_last = cyc + MD - 1;
        e_pcw = 1'b0; e_ifid = 1'b0; e_exh = 1'b1;
      end else if (hif.branch_taken) begin
        e_iff = 1'b1;
      end
    end
    exp_o = {e_pcw, e_ifid, e_iff, e_idex, e_exh, e_psv, e_ack, e_vec};
    got_o = {hif.pc_write, hif.if_id_write, hif.if_flush, hif.id_ex_flush,
             hif.ex_hold, hif.pc_sel_vector, hif.irq_ack, hif.vector_if_out};
`ifdef HAZARD_PERF_EN
    exp_sc = sc_model;
`else
    exp_sc = 0;
`endif
    n_checks++;
    if (got_o !== exp_o) begin
      n_fail++;
      $display("FAIL ctrl cyc=%0d got=%h exp=%h", cyc, got_o, exp_o);
    end
    n_checks++;
    if (int'(hif.stall_count) != exp_sc) begin
      n_fail++;
      $display("FAIL stall_count cyc=%0d got=%0h exp=%0h", cyc, hif.stall_count, exp_sc);
    end
    if (!reset && !e_pcw && sc_model < 65535) sc_model++;
    cyc++;
  end

  // ---------------- stimulus ----------------
  task automatic idle();
    hif.id_rs = '0; hif.id_rt = '0; hif.ex_mem_read = 1'b0; hif.ex_rt = '0;
    hif.branch_taken = 1'b0; hif.md_start = 1'b0;
    hif.irq_req = 1'b0; hif.irq_vector = '0;
  endtask

  task automatic lu_cycle();
    @(negedge clk);
    idle();
    hif.ex_mem_read = 1'b1; hif.ex_rt = 5'd9; hif.id_rt = 5'd9;
    @(negedge clk);
    idle();
  endtask

  int k;
  int n;
  int nfl;
  int bad;

  initial begin
    reset = 1'b1;
    idle();
    #3;
    chk("rst_pc_write", int'(hif.pc_write), 0);
    chk("rst_if_flush", int'(hif.if_flush), 1);
    chk("rst_id_ex_flush", int'(hif.id_ex_flush), 1);
    chk("rst_stall_count", int'(hif.stall_count), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // load-use with a taken branch: stall wins, branch ignored
    @(negedge clk);
    idle();
    hif.ex_mem_read = 1'b1; hif.ex_rt = 5'd5; hif.id_rs = 5'd5; hif.branch_taken = 1'b1;
    #3;
    chk("lu_pc_write", int'(hif.pc_write), 0);
    chk("lu_if_id_write", int'(hif.if_id_write), 0);
    chk("lu_id_ex_flush", int'(hif.id_ex_flush), 1);
    chk("lu_if_flush", int'(hif.if_flush), 0);
    // r0 destination never hazards; branch then flushes IF
    @(negedge clk);
    hif.ex_rt = 5'd0; hif.id_rs = 5'd0;
    #3;
    chk("lu_r0_pc_write", int'(hif.pc_write), 1);
    chk("lu_r0_if_id_write", int'(hif.if_id_write), 1);
    chk("lu_r0_if_flush", int'(hif.if_flush), 1);
    chk("lu_r0_id_ex_flush", int'(hif.id_ex_flush), 0);

    lu_cycle();
    lu_cycle();

    // mul/div: count consecutive frozen cycles
    @(negedge clk);
    idle();
    hif.md_start = 1'b1;
    #3;
    n = 0;
    for (int i = 0; i < 12; i++) begin
      if (!(hif.pc_write == 1'b0 && hif.ex_hold == 1'b1)) break;
      n++;
      @(negedge clk);
      hif.md_start = 1'b0;
      #3;
    end
    chk("md_stall_len", n, MD);
    chk("md_after_pc_write", int'(hif.pc_write), 1);
    chk("md_after_ex_hold", int'(hif.ex_hold), 0);
    @(negedge clk);
    #3;
`ifdef HAZARD_PERF_EN
    chk("perf_count_7", int'(hif.stall_count), 7);
`else
    chk("perf_count_off", int'(hif.stall_count), 0);
`endif

    // interrupt from RUN
    @(negedge clk);
    idle();
    hif.irq_req = 1'b1; hif.irq_vector = 5'h13;
    #3;
    chk("irq_accept_pc_write", int'(hif.pc_write), 0);
    chk("irq_accept_if_flush", int'(hif.if_flush), 1);
    k = 0; nfl = 0;
    while (hif.irq_ack !== 1'b1 && k < 12) begin
      @(negedge clk);
      #3;
      k++;
      if (hif.if_flush) nfl++;
    end
    chk("irq_latency", k, DR + 1);
    chk("irq_drain_flushes", nfl, DR);
    chk("irq_vector_out", int'(hif.vector_if_out), 'h13);
    chk("irq_pc_sel_vector", int'(hif.pc_sel_vector), 1);
    chk("irq_pc_write", int'(hif.pc_write), 1);
    @(negedge clk);
    idle();
    #3;
    chk("irq_ack_one_cycle", int'(hif.irq_ack), 0);

    // interrupt pulse during mul/div is deferred until MD completes
    @(negedge clk);
    idle();
    hif.md_start = 1'b1;
    #3;
    k = 0;
    for (int i = 1; i < 20; i++) begin
      @(negedge clk);
      idle();
      if (i == 2) begin
        hif.irq_req = 1'b1; hif.irq_vector = 5'h07;
      end else if (i > 2) begin
        hif.irq_vector = 5'h1F;
      end
      #3;
      k = i;
      if (i == MD - 1) chk("md_irq_still_hold", int'(hif.ex_hold), 1);
      if (hif.irq_ack === 1'b1) break;
    end
    chk("md_irq_ack_offset", k, MD + DR + 1);
    chk("md_irq_vector", int'(hif.vector_if_out), 'h07);
    @(negedge clk);
    idle();

    // async reset in the middle of DRAIN
    @(negedge clk);
    hif.irq_req = 1'b1; hif.irq_vector = 5'h1A;
    @(negedge clk);
    idle();
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("rstd_pc_write", int'(hif.pc_write), 0);
    chk("rstd_if_id_write", int'(hif.if_id_write), 0);
    chk("rstd_if_flush", int'(hif.if_flush), 1);
    chk("rstd_id_ex_flush", int'(hif.id_ex_flush), 1);
    chk("rstd_irq_ack", int'(hif.irq_ack), 0);
    chk("rstd_stall_count", int'(hif.stall_count), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      #3;
      if (hif.irq_ack !== 1'b0) bad++;
    end
    chk("rstd_no_ack_after", bad, 0);

`ifdef HAZARD_PERF_EN
    // long stall drives the counter into saturation
    @(negedge clk);
    idle();
    hif.ex_mem_read = 1'b1; hif.ex_rt = 5'd5; hif.id_rs = 5'd5;
    repeat (65540) @(negedge clk);
    #3;
    chk("perf_saturate", int'(hif.stall_count), 'hFFFF);
    @(negedge clk);
    #3;
    chk("perf_hold_ffff", int'(hif.stall_count), 'hFFFF);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    idle();
`endif

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      hif.id_rs        = 5'($urandom_range(0, 3));
      hif.id_rt        = 5'($urandom_range(0, 3));
      hif.ex_rt        = 5'($urandom_range(0, 3));
      hif.ex_mem_read  = ($urandom_range(0, 9) < 3);
      hif.branch_taken = ($urandom_range(0, 3) == 0);
      hif.md_start     = ($urandom_range(0, 9) == 0);
      hif.irq_req      = ($urandom_range(0, 15) == 0);
      hif.irq_vector   = 5'($urandom_range(0, 31));
      reset            = ($urandom_range(0, 399) == 0);
    end
    @(negedge clk);
    reset = 1'b0;
    idle();
    @(negedge clk);
    #4;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
